// File: rtl/alarm_ringer.sv
// Alarm ringer: compares the stored alarm time against the running clock and
// sequences ring / snooze / stop behaviour from second ticks and button pulses.
module alarm_ringer (
    input  logic       clk,
    input  logic       rst,
    input  logic       sec_tick,
    input  logic [1:0] cur_hours_left,
    input  logic [3:0] cur_hours_right,
    input  logic [2:0] cur_minutes_left,
    input  logic [3:0] cur_minutes_right,
    input  logic [1:0] alm_hours_left,
    input  logic [3:0] alm_hours_right,
    input  logic [2:0] alm_minutes_left,
    input  logic [3:0] alm_minutes_right,
    input  logic       alm_on,
    input  logic       ack_flag,
    input  logic       stop_button,
    input  logic       snooze_button,
    output logic       buzzer,
    output logic       ringing,
    output logic       snoozed,
    output logic       armed
);

    typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

    localparam logic [8:0] RING_LAST_SEC   = 9'd59;
    localparam logic [8:0] SNOOZE_LAST_SEC = 9'd299;
    localparam logic [1:0] MAX_SNOOZES     = 2'd3;

    state_t      state_reg, state_next;
    logic [12:0] alm_time_reg, alm_time_next;
    logic        armed_reg, armed_next;
    logic        match_d_reg;
    logic [8:0]  sec_cnt_reg, sec_cnt_next;
    logic [1:0]  snooze_cnt_reg, snooze_cnt_next;
    logic        beep_reg, beep_next;
    logic        buzzer_reg, ringing_reg, snoozed_reg;

    logic [12:0] cur_time;
    logic [12:0] alm_in;
    logic [12:0] bit_eq;
    logic        match;
    logic        trigger;

    assign cur_time = {cur_hours_left, cur_hours_right, cur_minutes_left, cur_minutes_right};
    assign alm_in   = {alm_hours_left, alm_hours_right, alm_minutes_left, alm_minutes_right};

    generate
        for (genvar gi = 0; gi < 13; gi++) begin : g_cmp
            assign bit_eq[gi] = ~(alm_time_reg[gi] ^ cur_time[gi]);
        end
    endgenerate

    assign match   = &bit_eq;
    // Only the first cycle of a matching minute fires, so a stopped alarm stays quiet.
    assign trigger = armed_reg & match & ~match_d_reg;

    always_comb begin
        state_next      = state_reg;
        alm_time_next   = alm_time_reg;
        armed_next      = armed_reg;
        sec_cnt_next    = sec_cnt_reg;
        snooze_cnt_next = snooze_cnt_reg;
        beep_next       = beep_reg;

        if (ack_flag) begin
            alm_time_next = alm_in;
            armed_next    = alm_on;
        end

        unique case (state_reg)
            IDLE: begin
                if (!ack_flag && trigger) begin
                    state_next      = RING;
                    sec_cnt_next    = '0;
                    beep_next       = 1'b1;
                    snooze_cnt_next = '0;
                end
            end
            RING: begin
                // Reload and stop take precedence over snooze and ticks.
                if (ack_flag || stop_button) begin
                    state_next = IDLE;
                end else if (snooze_button) begin
                    if (snooze_cnt_reg != MAX_SNOOZES) begin
                        state_next      = SNOOZE;
                        snooze_cnt_next = snooze_cnt_reg + 2'd1;
                        sec_cnt_next    = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (sec_tick) begin
                    beep_next    = ~beep_reg;
                    sec_cnt_next = sec_cnt_reg + 9'd1;
                    if (sec_cnt_reg == RING_LAST_SEC) begin
                        state_next = IDLE;
                    end
                end
            end
            SNOOZE: begin
                if (ack_flag || stop_button) begin
                    state_next = IDLE;
                end else if (sec_tick) begin
                    if (sec_cnt_reg == SNOOZE_LAST_SEC) begin
                        state_next   = RING;
                        sec_cnt_next = '0;
                        beep_next    = 1'b1;
                    end else begin
                        sec_cnt_next = sec_cnt_reg + 9'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            alm_time_reg   <= '0;
            armed_reg      <= 1'b0;
            match_d_reg    <= 1'b0;
            sec_cnt_reg    <= '0;
            snooze_cnt_reg <= '0;
            beep_reg       <= 1'b0;
            buzzer_reg     <= 1'b0;
            ringing_reg    <= 1'b0;
            snoozed_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            alm_time_reg   <= alm_time_next;
            armed_reg      <= armed_next;
            match_d_reg    <= match;
            sec_cnt_reg    <= sec_cnt_next;
            snooze_cnt_reg <= snooze_cnt_next;
            beep_reg       <= beep_next;
            // Output flops are fed from next-state so they line up with state_reg.
            buzzer_reg     <= (state_next == RING) & beep_next;
            ringing_reg    <= (state_next == RING);
            snoozed_reg    <= (state_next == SNOOZE);
        end
    end

    assign buzzer  = buzzer_reg;
    assign ringing = ringing_reg;
    assign snoozed = snoozed_reg;
    assign armed   = armed_reg;

endmodule

// File: tb/tb_alarm_ringer.sv
// Directed bench for alarm_ringer: each task drives one scenario and checks
// the packed output vector {ringing, snoozed, buzzer, armed} inline.
module tb_alarm_ringer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sec_tick = 1'b0;
    logic [1:0] cur_hours_left = '0;
    logic [3:0] cur_hours_right = '0;
    logic [2:0] cur_minutes_left = '0;
    logic [3:0] cur_minutes_right = '0;
    logic [1:0] alm_hours_left = '0;
    logic [3:0] alm_hours_right = '0;
    logic [2:0] alm_minutes_left = '0;
    logic [3:0] alm_minutes_right = '0;
    logic       alm_on = 1'b0;
    logic       ack_flag = 1'b0;
    logic       stop_button = 1'b0;
    logic       snooze_button = 1'b0;
    logic       buzzer, ringing, snoozed, armed;
    logic [3:0] outs;

    int checks = 0;
    int failures = 0;

    assign outs = {ringing, snoozed, buzzer, armed};

    always #5 clk = ~clk;

    alarm_ringer dut (
        .clk               (clk),
        .rst               (rst),
        .sec_tick          (sec_tick),
        .cur_hours_left    (cur_hours_left),
        .cur_hours_right   (cur_hours_right),
        .cur_minutes_left  (cur_minutes_left),
        .cur_minutes_right (cur_minutes_right),
        .alm_hours_left    (alm_hours_left),
        .alm_hours_right   (alm_hours_right),
        .alm_minutes_left  (alm_minutes_left),
        .alm_minutes_right (alm_minutes_right),
        .alm_on            (alm_on),
        .ack_flag          (ack_flag),
        .stop_button       (stop_button),
        .snooze_button     (snooze_button),
        .buzzer            (buzzer),
        .ringing           (ringing),
        .snoozed           (snoozed),
        .armed             (armed)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        sec_tick = 1'b1;
        repeat (n) step();
        sec_tick = 1'b0;
    endtask

    task automatic set_cur(input int hl, input int hr, input int ml, input int mr);
        cur_hours_left    = 2'(hl);
        cur_hours_right   = 4'(hr);
        cur_minutes_left  = 3'(ml);
        cur_minutes_right = 4'(mr);
    endtask

    task automatic load_alarm(input int hl, input int hr, input int ml, input int mr, input logic on);
        alm_hours_left    = 2'(hl);
        alm_hours_right   = 4'(hr);
        alm_minutes_left  = 3'(ml);
        alm_minutes_right = 4'(mr);
        alm_on            = on;
        ack_flag          = 1'b1;
        step();
        ack_flag          = 1'b0;
    endtask

    task automatic press_stop();
        stop_button = 1'b1;
        step();
        stop_button = 1'b0;
    endtask

    task automatic press_snooze();
        snooze_button = 1'b1;
        step();
        snooze_button = 1'b0;
    endtask

    // Clock goes 06:29 then 06:30; the edge sampling 06:30 fires the alarm.
    task automatic reach_0630();
        set_cur(0, 6, 2, 9);
        step();
        step();
        set_cur(0, 6, 3, 0);
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ack_flag = 1'b1;
        alm_on = 1'b1;
        step();
        step();
        ack_flag = 1'b0;
        alm_on = 1'b0;
        checks++;
        if (outs !== 4'b0000) begin
            failures++;
            $display("FAIL reset_state outs(r,s,b,a)=%b expected=%b", outs, 4'b0000);
        end
        rst = 1'b0;
        step();
        $display("test_reset done outs=%b", outs);
    endtask

    task automatic test_ring();
        load_alarm(0, 6, 3, 0, 1'b1);
        checks++;
        if (outs !== 4'b0001) begin
            failures++;
            $display("FAIL ring_load outs=%b expected=%b", outs, 4'b0001);
        end
        reach_0630();
        checks++;
        if (outs !== 4'b1011) begin
            failures++;
            $display("FAIL ring_entry outs=%b expected=%b", outs, 4'b1011);
        end
        ticks(1);
        checks++;
        if (outs !== 4'b1001) begin
            failures++;
            $display("FAIL ring_toggle1 outs=%b expected=%b", outs, 4'b1001);
        end
        ticks(1);
        checks++;
        if (outs !== 4'b1011) begin
            failures++;
            $display("FAIL ring_toggle2 outs=%b expected=%b", outs, 4'b1011);
        end
        ticks(57);
        checks++;
        if (outs !== 4'b1001) begin
            failures++;
            $display("FAIL ring_59ticks outs=%b expected=%b", outs, 4'b1001);
        end
        ticks(1);
        checks++;
        if (outs !== 4'b0001) begin
            failures++;
            $display("FAIL ring_autostop outs=%b expected=%b", outs, 4'b0001);
        end
        step();
        step();
        checks++;
        if (outs !== 4'b0001) begin
            failures++;
            $display("FAIL ring_no_retrigger outs=%b expected=%b", outs, 4'b0001);
        end
        $display("test_ring done outs=%b", outs);
    endtask

    task automatic test_stop();
        reach_0630();
        press_stop();
        checks++;
        if (outs !== 4'b0001) begin
            failures++;
            $display("FAIL stop_idle outs=%b expected=%b", outs, 4'b0001);
        end
        ticks(59);
        checks++;
        if (outs !== 4'b0001) begin
            failures++;
            $display("FAIL stop_no_retrigger outs=%b expected=%b", outs, 4'b0001);
        end
        $display("test_stop done outs=%b", outs);
    endtask

    task automatic test_snooze();
        reach_0630();
        for (int i = 0; i < 3; i++) begin
            press_snooze();
            checks++;
            if (outs !== 4'b0101) begin
                failures++;
                $display("FAIL snooze_enter%0d outs=%b expected=%b", i, outs, 4'b0101);
            end
            ticks(299);
            checks++;
            if (outs !== 4'b0101) begin
                failures++;
                $display("FAIL snooze_hold%0d outs=%b expected=%b", i, outs, 4'b0101);
            end
            ticks(1);
            checks++;
            if (outs !== 4'b1011) begin
                failures++;
                $display("FAIL snooze_rering%0d outs=%b expected=%b", i, outs, 4'b1011);
            end
        end
        press_snooze();
        checks++;
        if (outs !== 4'b0001) begin
            failures++;
            $display("FAIL snooze_fourth_stops outs=%b expected=%b", outs, 4'b0001);
        end
        $display("test_snooze done outs=%b", outs);
    endtask

    task automatic test_disarmed();
        load_alarm(0, 6, 3, 0, 1'b0);
        checks++;
        if (outs !== 4'b0000) begin
            failures++;
            $display("FAIL disarmed_load outs=%b expected=%b", outs, 4'b0000);
        end
        reach_0630();
        step();
        checks++;
        if (outs !== 4'b0000) begin
            failures++;
            $display("FAIL disarmed_no_ring outs=%b expected=%b", outs, 4'b0000);
        end
        $display("test_disarmed done outs=%b", outs);
    endtask

    task automatic test_buttons_and_ack();
        load_alarm(0, 6, 3, 0, 1'b1);
        reach_0630();
        stop_button = 1'b1;
        snooze_button = 1'b1;
        step();
        stop_button = 1'b0;
        snooze_button = 1'b0;
        checks++;
        if (outs !== 4'b0001) begin
            failures++;
            $display("FAIL both_buttons outs=%b expected=%b", outs, 4'b0001);
        end
        reach_0630();
        press_snooze();
        checks++;
        if (outs !== 4'b0101) begin
            failures++;
            $display("FAIL ack_pre_snooze outs=%b expected=%b", outs, 4'b0101);
        end
        sec_tick = 1'b1;
        load_alarm(0, 6, 3, 0, 1'b0);
        sec_tick = 1'b0;
        checks++;
        if (outs !== 4'b0000) begin
            failures++;
            $display("FAIL ack_in_snooze outs=%b expected=%b", outs, 4'b0000);
        end
        // Reload on the very edge the trigger would fire: stays idle.
        load_alarm(0, 6, 3, 0, 1'b1);
        set_cur(0, 6, 2, 9);
        step();
        step();
        set_cur(0, 6, 3, 0);
        load_alarm(0, 6, 3, 0, 1'b1);
        checks++;
        if (outs !== 4'b0001) begin
            failures++;
            $display("FAIL ack_with_trigger outs=%b expected=%b", outs, 4'b0001);
        end
        step();
        checks++;
        if (outs !== 4'b0001) begin
            failures++;
            $display("FAIL ack_with_trigger_after outs=%b expected=%b", outs, 4'b0001);
        end
        $display("test_buttons_and_ack done outs=%b", outs);
    endtask

    task automatic test_reset_mid_ring();
        reach_0630();
        ticks(25);
        checks++;
        if (outs !== 4'b1001) begin
            failures++;
            $display("FAIL mid_ring_25 outs=%b expected=%b", outs, 4'b1001);
        end
        rst = 1'b1;
        stop_button = 1'b1;
        sec_tick = 1'b1;
        step();
        stop_button = 1'b0;
        sec_tick = 1'b0;
        checks++;
        if (outs !== 4'b0000) begin
            failures++;
            $display("FAIL mid_ring_reset outs=%b expected=%b", outs, 4'b0000);
        end
        rst = 1'b0;
        set_cur(0, 0, 0, 0);
        step();
        step();
        step();
        checks++;
        if (outs !== 4'b0000) begin
            failures++;
            $display("FAIL post_reset_no_trigger outs=%b expected=%b", outs, 4'b0000);
        end
        $display("test_reset_mid_ring done outs=%b", outs);
    endtask

    initial begin
        test_reset();
        test_ring();
        test_stop();
        test_snooze();
        test_disarmed();
        test_buttons_and_ack();
        test_reset_mid_ring();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alarm_ringer.md
ALARM_RINGER -- requirements
Module: alarm_ringer

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous and active-high.
REQ-003 sec_tick  input  1  one-cycle pulse per second from the timebase.
REQ-004 cur_hours_left  input  2, cur_hours_right input 4, cur_minutes_left input 3, cur_minutes_right input 4  current BCD time digits from the clock counter.
REQ-005 alm_hours_left  input  2, alm_hours_right input 4, alm_minutes_left input 3, alm_minutes_right input 4  alarm BCD digits from the alarm-setting stage.
REQ-006 alm_on  input  1  alarm enable from the alarm-setting stage.
REQ-007 ack_flag  input  1  alarm-setting complete strobe; load alarm digits and alm_on.
REQ-008 stop_button  input  1  one-cycle pulse, stops the alarm.
REQ-009 snooze_button  input  1  one-cycle pulse, snoozes the alarm.
REQ-010 buzzer  output  1  beep drive, registered.
REQ-011 ringing  output  1  high in RING state, registered.
REQ-012 snoozed  output  1  high in SNOOZE state, registered.
REQ-013 armed  output  1  stored alarm enable, registered.

Function
REQ-014 Block SHALL hold a 13-bit stored alarm time and armed bit, loaded on any cycle ack_flag=1 from alm_* and alm_on.
REQ-015 match SHALL be 1 when all four stored digits equal the four cur_* digits (combinational compare); match_d SHALL be match registered one cycle.
REQ-016 Trigger SHALL be armed=1 AND match=1 AND match_d=0 (rising edge of match); one trigger per matching minute.
REQ-017 FSM states IDLE, RING, SNOOZE; reset state IDLE.
REQ-018 IDLE: on trigger -> RING next cycle; sec counter cleared, beep=1, snooze_cnt cleared.
REQ-019 RING: beep SHALL toggle on each sec_tick; buzzer=beep in RING, 0 elsewhere.
REQ-020 RING: sec counter (9-bit) increments per sec_tick; at 60th sec_tick -> IDLE (auto-stop, no snooze).
REQ-021 RING: stop_button -> IDLE next cycle.
REQ-022 RING: snooze_button with snooze_cnt<3 -> SNOOZE, snooze_cnt+1, sec counter cleared.
REQ-023 RING: snooze_button with snooze_cnt=3 SHALL act as stop -> IDLE.
REQ-024 SNOOZE: sec counter increments per sec_tick; at 300th sec_tick -> RING, sec counter cleared, beep=1.
REQ-025 SNOOZE: stop_button -> IDLE; snooze_button ignored.
REQ-026 Simultaneous stop_button and snooze_button SHALL be treated as stop.
REQ-027 ack_flag=1 in RING or SNOOZE SHALL reload stored values and force IDLE next cycle, regardless of buttons or sec_tick same cycle.
REQ-028 ack_flag=1 in same cycle as a trigger condition SHALL load and stay IDLE; match_d still updates.
REQ-029 Trigger ignored while in RING or SNOOZE.
REQ-030 Outputs ringing/snoozed SHALL reflect the state register (no extra latency beyond state update); buzzer one cycle after entry = 1.

Reset
REQ-031 rst=1 SHALL set state IDLE, stored digits 0, armed 0, match_d 0, sec counter 0, snooze_cnt 0, beep 0, buzzer/ringing/snoozed/armed 0 on next edge.
REQ-032 rst SHALL override ack_flag, buttons and sec_tick, including mid-RING or mid-SNOOZE.

Verification
REQ-033 Load 06:30 alm_on=1 via ack_flag; cur steps 06:29->06:30 -> ringing=1 next cycle, buzzer=1, then toggles each sec_tick; after 60 sec_ticks ringing=0.
REQ-034 Ringing at 06:30, stop_button -> ringing=0; cur held 06:30 for 59 more sec_ticks -> no retrigger.
REQ-035 Ringing, snooze_button -> snoozed=1, buzzer=0; 300 sec_ticks -> ringing=1; repeat 3 snoozes, 4th snooze_button -> ringing=0, snoozed=0.
REQ-036 Load 06:30 alm_on=0 -> armed=0, cur reaches 06:30 -> ringing stays 0.
REQ-037 Ringing, stop_button and snooze_button same cycle -> IDLE; in SNOOZE, ack_flag with alm_on=0 -> IDLE, armed=0.
REQ-038 rst=1 during RING at sec count 25 -> all outputs 0 next edge; stored time 00:00, cur 00:00 after release -> no trigger (armed=0).
